// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared AXIS width constants and arbiter state encoding
package axis_arb_pkg;
    localparam int AXIS_DATA_WIDTH = 512;
    localparam int AXIS_KEEP_WIDTH = 64;
    localparam int AXIS_USER_WIDTH = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;
endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry registered AXIS skid stage, 1-cycle latency, full throughput
module axis_skid_buf #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic [KEEP_WIDTH-1:0] in_tkeep,
    input  logic                  in_tlast,
    input  logic [USER_WIDTH-1:0] in_tuser,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic [KEEP_WIDTH-1:0] out_tkeep,
    output logic                  out_tlast,
    output logic [USER_WIDTH-1:0] out_tuser
);
    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] main_beat;
    logic [BEAT_W-1:0] skid_beat;
    logic              main_valid;
    logic              skid_valid;
    logic              push;
    logic              main_free;

    assign in_beat   = {in_tdata, in_tkeep, in_tuser, in_tlast};
    // Ready depends only on registered state, so upstream sees no combinational path from out_tready.
    assign in_tready = ~skid_valid;
    assign push      = in_tvalid & ~skid_valid;
    assign main_free = ~main_valid | out_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_beat  <= '0;
            skid_beat  <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_beat  <= skid_beat;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (push) begin
                main_beat  <= in_beat;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (push) begin
            skid_beat  <= in_beat;
            skid_valid <= 1'b1;
        end
    end

    assign out_tvalid = main_valid;
    assign {out_tdata, out_tkeep, out_tuser, out_tlast} = main_beat;
endmodule

// File: rtl/axis_tx_pkt_arbiter.sv
// rtl/axis_tx_pkt_arbiter.sv - packet-granular 2:1 round-robin AXIS arbiter for CMAC TX
// Optional statistics counters enabled by AXIS_TX_PKT_ARB_STATS_EN.
import axis_arb_pkg::*;

module axis_tx_pkt_arbiter #(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int KEEP_WIDTH = AXIS_KEEP_WIDTH,
    parameter int USER_WIDTH = AXIS_USER_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tlast,
    input  logic [USER_WIDTH-1:0] s0_axis_tuser,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tlast,
    input  logic [USER_WIDTH-1:0] s1_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser
`ifdef AXIS_TX_PKT_ARB_STATS_EN
    ,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1,
    output logic [31:0]           beat_cnt
`endif
);
    arb_state_t            state, state_nxt, other_grant;
    logic                  rr_ptr, rr_ptr_nxt;
    logic                  sof, sof_nxt;
    logic                  skid_in_ready;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  other_valid;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;

    assign s0_axis_tready = (state == GRANT0) & skid_in_ready;
    assign s1_axis_tready = (state == GRANT1) & skid_in_ready;

    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = s0_axis_tlast;
        sel_data    = s0_axis_tdata;
        sel_keep    = s0_axis_tkeep;
        sel_user    = s0_axis_tuser;
        other_valid = s1_axis_tvalid;
        other_grant = GRANT1;
        if (state == GRANT0) begin
            sel_valid = s0_axis_tvalid;
        end else if (state == GRANT1) begin
            sel_valid   = s1_axis_tvalid;
            sel_last    = s1_axis_tlast;
            sel_data    = s1_axis_tdata;
            sel_keep    = s1_axis_tkeep;
            sel_user    = s1_axis_tuser;
            other_valid = s0_axis_tvalid;
            other_grant = GRANT0;
        end
    end

    assign accept = sel_valid & skid_in_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
            sof    <= 1'b1;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            sof    <= sof_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        sof_nxt    = sof;
        unique case (state)
            IDLE: begin
                sof_nxt = 1'b1;
                if (rr_ptr ? s1_axis_tvalid : s0_axis_tvalid) begin
                    state_nxt = rr_ptr ? GRANT1 : GRANT0;
                end else if (rr_ptr ? s0_axis_tvalid : s1_axis_tvalid) begin
                    state_nxt = rr_ptr ? GRANT0 : GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept) begin
                    sof_nxt = sel_last;
                    if (sel_last) begin
                        rr_ptr_nxt = (state == GRANT0);
                        state_nxt  = other_valid ? other_grant : state;
                    end
                end else if (sof && !sel_valid) begin
                    // Between frames with the owner idle: release so the other port cannot starve.
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    axis_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH),
        .USER_WIDTH(USER_WIDTH)
    ) u_skid (
        .clk       (CLK),
        .rst       (RST),
        .in_tvalid (sel_valid),
        .in_tready (skid_in_ready),
        .in_tdata  (sel_data),
        .in_tkeep  (sel_keep),
        .in_tlast  (sel_last),
        .in_tuser  (sel_user),
        .out_tvalid(m_axis_tvalid),
        .out_tready(m_axis_tready),
        .out_tdata (m_axis_tdata),
        .out_tkeep (m_axis_tkeep),
        .out_tlast (m_axis_tlast),
        .out_tuser (m_axis_tuser)
    );

`ifdef AXIS_TX_PKT_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            beat_cnt <= '0;
        end else begin
            if (accept && sel_last && state == GRANT0) pkt_cnt0 <= pkt_cnt0 + 32'd1;
            if (accept && sel_last && state == GRANT1) pkt_cnt1 <= pkt_cnt1 + 32'd1;
            if (m_axis_tvalid && m_axis_tready) beat_cnt <= beat_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: doc/axis_tx_pkt_arbiter.md
Name: axis_tx_pkt_arbiter

Overview:
Packet-granular round-robin arbiter sharing the single CMAC TX AXI-Stream between two requesters: port 0 (UDP/IP/Eth TX stack output) and port 1 (XDMA raw bypass TX). A grant is held from first beat to tlast, so frames never interleave. Output passes through a registered skid stage, giving 1-cycle latency at full throughput. It sits between the TX sources and the cmacAxiStreamTxOut interface of the bypass RxTx top.

Parameters:
DATA_WIDTH, 512, tdata width
KEEP_WIDTH, 64, tkeep width (DATA_WIDTH/8)
USER_WIDTH, 1, tuser width

Ports:
CLK  input  1  single clock, all logic rising-edge
RST  input  1  synchronous, active-high reset
s0_axis_tvalid  input  1  port 0 valid
s0_axis_tready  output  1  port 0 ready
s0_axis_tdata  input  DATA_WIDTH  port 0 data
s0_axis_tkeep  input  KEEP_WIDTH  port 0 byte enables
s0_axis_tlast  input  1  port 0 end of frame
s0_axis_tuser  input  USER_WIDTH  port 0 user
s1_axis_* (tvalid, tready, tdata, tkeep, tlast, tuser): same widths, directions and meanings as the s0_axis_* signals, for port 1
m_axis_tvalid  output  1  to CMAC TX
m_axis_tready  input  1  from CMAC TX
m_axis_tdata  output  DATA_WIDTH  output data
m_axis_tkeep  output  KEEP_WIDTH  output byte enables
m_axis_tlast  output  1  output end of frame
m_axis_tuser  output  USER_WIDTH  output user

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, skid stage empty; m_axis_tvalid=0, s0/s1_axis_tready=0, m_axis_tdata/tkeep/tlast/tuser=0.
- FSM states:
  - IDLE: if rr_ptr's port tvalid=1, go to GRANTrr_ptr; else if the other port tvalid=1, go to GRANTother; else stay in IDLE. The decision is registered, so there is 1 bubble cycle from IDLE; no tready is asserted in IDLE.
  - GRANTn: sn_axis_tready = skid_in_ready; the other port's tready=0. A beat transfers when sn_axis_tvalid & sn_axis_tready.
  - On accepting a tlast=1 beat in GRANTn: rr_ptr<=~n. Next state is GRANT~n if s~n_axis_tvalid=1 in that cycle, else GRANTn if sn_axis_tvalid=1, else IDLE. The back-to-back switch has no bubble.
- Grant never changes mid-frame, regardless of the other port's tvalid.
- Skid stage: 2-entry (main + skid) register pair.
  - skid_in_ready = skid entry empty.
  - Latency is 1 cycle input-to-output; sustains 1 beat/cycle under continuous m_axis_tready.
  - Output holds stable while m_axis_tvalid & ~m_axis_tready (AXIS rule).
- tkeep/tuser/tdata pass unmodified; no width arithmetic.
- Single-beat frames (tvalid & tlast on first beat) are legal and switch grant immediately.
- Simultaneous first requests from IDLE: rr_ptr wins; at reset, port 0 wins.
- Source dropping tvalid mid-frame: grant held and tready stays asserted; nothing is forwarded until the source resumes.
- Reset mid-frame: all state cleared the next edge; any partial frame already issued to CMAC is truncated and the remainder is not forwarded. Upstream sources must be reset together with this block.

Optional Feature:
Macro AXIS_TX_PKT_ARB_STATS_EN.
- Defined: adds outputs pkt_cnt0[31:0], pkt_cnt1[31:0] and beat_cnt[31:0].
  - pkt_cnt0/pkt_cnt1 increment on an accepted tlast beat from port 0/1.
  - beat_cnt increments on every accepted m_axis beat.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; the datapath is identical.

Decomposition:
- Shared package axis_arb_pkg:
  - AXIS width constants (512/64/1).
  - State enum IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2.
- One sub-module axis_skid_buf (parameterised DATA/KEEP/USER widths), reused on other CMAC/XDMA paths.

Test Plan:
1. Port 0 only, 3 frames of 4 beats, m_axis_tready=1 -> 12 beats out, tlast on beats 4/8/12, first output 2 cycles after first s0 tvalid, then no bubbles between frames.
2. Both ports continuously valid, 2-beat frames, starting from reset -> output order is frame s0, s1, s0, s1; no interleaving; rr_ptr toggles each tlast.
3. Port 0 mid-frame (beat 2 of 5) when s1 asserts tvalid -> s1_axis_tready stays 0 until s0 tlast accepted, then s1 frame starts on the next beat.
4. m_axis_tready random 50%, data incrementing 0..N -> output sequence identical, no drop or duplicate, output held stable when stalled.
5. RST asserted 1 cycle during beat 3 of 6 -> next cycle m_axis_tvalid=0, both treadys=0, state=IDLE, rr_ptr=0.
6. With AXIS_TX_PKT_ARB_STATS_EN, 5 frames on s0 and 3 frames on s1, 4 beats each -> pkt_cnt0=5, pkt_cnt1=3, beat_cnt=32.
